// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sequenced IDLE -> PREP -> CALC -> FIN behind a start/done handshake.
module mdu_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  KILL,
    input  logic [5:0]            SELECT,
    input  logic [DATA_WIDTH-1:0] DATA1,
    input  logic [DATA_WIDTH-1:0] DATA2,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  DONE,
    output logic                  BUSY,
    output logic                  ILLEGAL
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   d1_q, d1_d, d2_q, d2_d;
    logic [W-1:0]   opb_q, opb_d, result_q, result_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d, done_q, done_d;
    logic           busy_q, busy_d, illegal_q, illegal_d;

    logic           legal_sel, is_div, is_rem, sign1, sign2, div_zero, div_ovf;
    logic [W-1:0]   mag1, mag2, restore;
    logic [W:0]     mul_sum, div_part, div_diff;
    logic [2*W-1:0] prod;

    assign legal_sel = (SELECT[5:3] == 3'b001);
    assign is_div    = op_q[2];
    assign is_rem    = op_q[2] & op_q[1];
    // Only MULHU, DIVU and REMU treat DATA1 as unsigned; MULHSU also leaves DATA2 unsigned.
    assign sign1     = d1_q[W-1] & (op_q != 3'd3) & (op_q != 3'd5) & (op_q != 3'd7);
    assign sign2     = d2_q[W-1] & ((op_q == 3'd0) | (op_q == 3'd1) | (op_q == 3'd4) | (op_q == 3'd6));
    assign mag1      = sign1 ? -d1_q : d1_q;
    assign mag2      = sign2 ? -d2_q : d2_q;
    assign div_zero  = is_div & (d2_q == '0);
    assign div_ovf   = is_div & ~op_q[0] & (d1_q == MIN_NEG) & (&d2_q);

    // acc holds {partial product high, multiplier} or {partial remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_part  = {acc_q[2*W-1:W], acc_q[W-1]};
    assign restore   = {acc_q[2*W-2:W], acc_q[W-1]};
    assign div_diff  = div_part - {1'b0, opb_q};
    assign prod      = neg_q ? -acc_q : acc_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (START && !legal_sel) begin
                    illegal_d = 1'b1;
                end else if (START && !KILL) begin
                    op_d    = SELECT[2:0];
                    d1_d    = DATA1;
                    d2_d    = DATA2;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                cnt_d = CNT_INIT;
                neg_d = is_rem ? sign1 : (sign1 ^ sign2);
                if (div_zero) begin
                    acc_d   = {d1_q, {W{1'b1}}};
                    neg_d   = 1'b0;
                    state_d = FIN;
                end else if (div_ovf) begin
                    acc_d   = {{W{1'b0}}, MIN_NEG};
                    neg_d   = 1'b0;
                    state_d = FIN;
                end else if (is_div) begin
                    acc_d   = {{W{1'b0}}, mag1};
                    opb_d   = mag2;
                    state_d = CALC;
                end else begin
                    acc_d   = {{W{1'b0}}, mag2};
                    opb_d   = mag1;
                    state_d = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q - CNT_ONE;
                if (is_div) begin
                    acc_d = div_diff[W] ? {restore, acc_q[W-2:0], 1'b0}
                                        : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                if (cnt_q == CNT_ONE) state_d = FIN;
            end
            FIN: begin
                if (is_rem)        result_d = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                else if (is_div)   result_d = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
                else if (op_q == 3'd0) result_d = prod[W-1:0];
                else               result_d = prod[2*W-1:W];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A flush overrides everything, including the FIN write-back.
        if (KILL && state_q != IDLE) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            op_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q   <= state_d;
            op_q      <= op_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
        end
    end

    assign RESULT  = result_q;
    assign DONE    = done_q;
    assign BUSY    = busy_q;
    assign ILLEGAL = illegal_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: table of ops scored through a queue,
// plus hand-written kill, ignored-start, illegal and mid-op reset sequences.
module tb_mdu_sequencer;
    localparam int W = 32;
    localparam logic [5:0] OP_MUL = 6'b001000, OP_MULH = 6'b001001, OP_MULHSU = 6'b001010,
                           OP_MULHU = 6'b001011, OP_DIV = 6'b001100, OP_DIVU = 6'b001101,
                           OP_REM = 6'b001110, OP_REMU = 6'b001111;

    typedef struct {
        string        name;
        logic [5:0]   sel;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] exp;
        int           lat;
        int           acc_cyc;
    } sb_t;

    logic         CLK = 1'b0, RESET = 1'b0, START = 1'b0, KILL = 1'b0;
    logic [5:0]   SELECT = '0;
    logic [W-1:0] DATA1 = '0, DATA2 = '0;
    logic [W-1:0] RESULT;
    logic         DONE, BUSY, ILLEGAL;

    sb_t          sb[$];
    vec_t         vecs[$];
    int           n_checks = 0, n_fail = 0, cyc = 0;
    logic [W-1:0] last_result = '0;

    mdu_sequencer #(.DATA_WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .KILL(KILL), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .DONE(DONE), .BUSY(BUSY),
        .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every DONE must match the oldest outstanding request.
    always @(negedge CLK) begin : monitor
        sb_t e;
        if (DONE) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, RESULT, e.exp);
                check({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
            end
        end
    end

    task automatic run_op(input vec_t v, input bit intrude);
        int  n;
        bit  busy_ok;
        bit  extra;
        sb_t e;
        @(negedge CLK);
        START = 1'b1; SELECT = v.sel; DATA1 = v.d1; DATA2 = v.d2;
        @(negedge CLK);
        START = 1'b0; DATA1 = $urandom; DATA2 = $urandom;
        e = '{v.name, v.exp, v.lat, cyc};
        sb.push_back(e);
        busy_ok = 1'b1;
        n = 0;
        while (!DONE && n < 100) begin
            if (!BUSY) busy_ok = 1'b0;
            if (intrude && n == 5) begin
                START = 1'b1; SELECT = OP_MUL; DATA1 = 32'd3; DATA2 = 32'd5;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            n++;
        end
        START = 1'b0;
        if (!DONE) begin
            check({v.name, "_timeout"}, 0, 1);
            sb.delete(sb.size() - 1);
        end else begin
            if (!BUSY) busy_ok = 1'b0;
            last_result = v.exp;
        end
        check({v.name, "_busy_high"}, busy_ok, 1);
        @(negedge CLK);
        check({v.name, "_busy_fall"}, BUSY, 0);
        if (intrude) begin
            extra = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (DONE) extra = 1'b1;
                @(negedge CLK);
            end
            check("ignored_start_single_done", extra, 0);
        end
    endtask

    initial begin
        bit saw_done;

        vecs.push_back('{"mul_neg",     OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34});
        vecs.push_back('{"mulh_min",    OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34});
        vecs.push_back('{"mulhu_max",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vecs.push_back('{"mulhsu_max",  OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
        vecs.push_back('{"mulhsu_pos",  OP_MULHSU, 32'd2,        32'hFFFFFFFF, 32'h00000001, 34});
        vecs.push_back('{"mulh_neg1",   OP_MULH,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34});
        vecs.push_back('{"mulh_minm1",  OP_MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34});
        vecs.push_back('{"mulhu_2p16",  OP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 34});
        vecs.push_back('{"mul_2p16",    OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 34});
        vecs.push_back('{"div_neg",     OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
        vecs.push_back('{"rem_neg",     OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
        vecs.push_back('{"div_negdiv",  OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34});
        vecs.push_back('{"rem_negdiv",  OP_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 34});
        vecs.push_back('{"divu",        OP_DIVU,   32'd100,      32'd7,        32'd14,       34});
        vecs.push_back('{"remu",        OP_REMU,   32'd100,      32'd7,        32'd2,        34});
        vecs.push_back('{"divu_big",    OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34});
        vecs.push_back('{"divu_minm1",  OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34});
        vecs.push_back('{"divu_zero",   OP_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 2});
        vecs.push_back('{"remu_zero",   OP_REMU,   32'h1234,     32'd0,        32'h00001234, 2});
        vecs.push_back('{"rem_zero_neg",OP_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2});
        vecs.push_back('{"div_ovf",     OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
        vecs.push_back('{"rem_ovf",     OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2});

        #1 RESET = 1'b1;
        #1;
        check("reset_result", RESULT, 0);
        check("reset_done", DONE, 0);
        check("reset_busy", BUSY, 0);
        check("reset_illegal", ILLEGAL, 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        foreach (vecs[i]) run_op(vecs[i], 1'b0);

        // Kill a signed divide at cycle 10.
        @(negedge CLK);
        START = 1'b1; SELECT = OP_DIV; DATA1 = 32'hFFFFFFF9; DATA2 = 32'd2;
        @(negedge CLK);
        START = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 45; n++) begin
            if (n == 9) check("kill_busy_before", BUSY, 1);
            if (n == 12) check("kill_busy_low", BUSY, 0);
            KILL = (n == 10);
            if (DONE) saw_done = 1'b1;
            @(negedge CLK);
        end
        KILL = 1'b0;
        check("kill_no_done", saw_done, 0);
        check("kill_result_kept", RESULT, last_result);

        run_op('{"mul_3x5", OP_MUL, 32'd3, 32'd5, 32'd15, 34}, 1'b0);
        run_op('{"divu_busy_start", OP_DIVU, 32'd100, 32'd7, 32'd14, 34}, 1'b1);

        // Illegal selects just below and just above the legal range.
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            START = 1'b1; SELECT = (i == 0) ? 6'b000000 : 6'b010000; DATA1 = 32'd1; DATA2 = 32'd1;
            @(negedge CLK);
            START = 1'b0;
            check("illegal_pulse", ILLEGAL, 1);
            check("illegal_busy", BUSY, 0);
            @(negedge CLK);
            check("illegal_one_cycle", ILLEGAL, 0);
            check("illegal_not_accepted", BUSY, 0);
            check("illegal_result_kept", RESULT, last_result);
        end

        // Reset in the middle of CALC.
        @(negedge CLK);
        START = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        check("prereset_busy", BUSY, 1);
        #2 RESET = 1'b1;
        #1;
        check("midreset_result", RESULT, 0);
        check("midreset_busy", BUSY, 0);
        check("midreset_done", DONE, 0);
        check("midreset_illegal", ILLEGAL, 0);
        @(negedge CLK);
        RESET = 1'b0;
        last_result = '0;
        saw_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (DONE) saw_done = 1'b1;
            @(negedge CLK);
        end
        check("midreset_no_done", saw_done, 0);

        run_op('{"remu_after_reset", OP_REMU, 32'd100, 32'd7, 32'd2, 34}, 1'b0);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end
endmodule
